// File: rtl/dbus_arbiter.sv
// dbus_arbiter
//   Shares the single data-bus master port between two requesters:
//   port 0 (memory-stage load/store) and port 1 (page-table walker or other
//   auxiliary data-side master). A grant covers exactly one transaction,
//   from the granting cycle through the data_ok cycle.
//
//   Build option: define ARB_ROUND_ROBIN_EN to resolve simultaneous requests
//   by alternation (winner is the port not granted last). Without it,
//   HIGH_PRIO always wins contention.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset
//   req0   in   port 0 request  (valid, addr, size, strobe, data)
//   resp0  out  port 0 response (addr_ok, data_ok, data)
//   req1   in   port 1 request
//   resp1  out  port 1 response
//   dreq   out  merged request to the top-level dbus
//   dresp  in   response from the top-level dbus
//   busy   out  high while a granted transaction is outstanding
//   owner  out  port currently or last granted
//
// State | meaning
//   IDLE  | no transaction held; arbitration is combinational
//   BUSY  | owner's transaction issued, waiting for data_ok

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter logic HIGH_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  dbus_req_t  req0,
    output dbus_resp_t resp0,
    input  dbus_req_t  req1,
    output dbus_resp_t resp1,
    output dbus_req_t  dreq,
    input  dbus_resp_t dresp,
    output logic       busy,
    output logic       owner
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   contend_pick;
    logic   sel;
    logic   active;

`ifdef ARB_ROUND_ROBIN_EN
    logic   last_grant_q, last_grant_d;
    assign contend_pick = ~last_grant_q;
`else
    assign contend_pick = HIGH_PRIO;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        sel     = owner_q;
        active  = 1'b0;
        dreq    = '0;
        resp0   = '0;
        resp1   = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif

        if (state_q == S_BUSY) begin
            // Grant is held until data_ok even if the owner misbehaves and
            // drops valid; the bus still sees the owner's request.
            active = 1'b1;
            if (dresp.data_ok) begin
                state_d = S_IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_d = owner_q;
`endif
            end
        end else if (req0.valid || req1.valid) begin
            active  = 1'b1;
            sel     = (req0.valid && req1.valid) ? contend_pick : req1.valid;
            owner_d = sel;
            // Zero-wait completion finishes inside the granting cycle.
            if (dresp.data_ok) begin
`ifdef ARB_ROUND_ROBIN_EN
                last_grant_d = sel;
`endif
            end else begin
                state_d = S_BUSY;
            end
        end

        if (active && !rst) begin
            if (sel) begin
                dreq  = req1;
                resp1 = dresp;
            end else begin
                dreq  = req0;
                resp0 = dresp;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= ~HIGH_PRIO;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Reset forces the visible status low immediately, not one cycle late.
    assign busy  = (state_q == S_BUSY) && !rst;
    assign owner = rst ? 1'b0 : owner_q;

    // Requester contract: the owner keeps valid high until its data_ok.
    owner_holds_valid: assert property (
        @(posedge clk) disable iff (rst)
        (state_q == S_BUSY) |-> (owner_q ? req1.valid : req0.valid)
    );

endmodule
